split_assign_loader: RTL and testbench

- Producer side of the split-constraint interface. Receives a candidate variable assignment as a 32-bit word stream from the solver host.
- Unpacks the stream into the 654-bit flat assignment vector (var_0..var_19 concatenated) and presents it to a split constraint checker.
- Samples the checker's x output and returns a pass/fail result over a valid/ready handshake, with framing-error detection and running counters.

---
 rtl/split_pkg.sv | 31 +++
 rtl/split_vec_unpack.sv | 51 +++++
 rtl/split_assign_loader.sv | 132 +++++++++++++
 tb/tb_split_assign_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared constants for the split-constraint blocks.
// Latency: n/a (package). Backpressure: n/a.
// Holds the stream geometry, the 20-field layout of the flat assignment vector and the loader FSM states.
package split_pkg;

   localparam int WORD_W  = 32;
   localparam int TOTAL_W = 654;
   localparam int WORDS   = (TOTAL_W + WORD_W - 1) / WORD_W;
   // Bits of the final stream word that carry assignment data; the rest are ignored.
   localparam int LAST_W  = TOTAL_W - (WORDS - 1) * WORD_W;
   localparam int NVARS   = 20;

   localparam int VAR_W [0:NVARS-1] = '{
      27, 41, 29, 52, 46, 25, 17, 29,  6, 38,
      47, 41, 27, 52, 27, 40, 29, 53,  8, 20
   };

   // Running sums of VAR_W; var_0 sits at the LSBs.
   localparam int VAR_OFF [0:NVARS-1] = '{
        0,  27,  68,  97, 149, 195, 220, 237, 266, 272,
      310, 357, 398, 425, 477, 504, 544, 573, 626, 634
   };

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      DRAIN = 2'd1,
      CHECK = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/split_vec_unpack.sv
// Slices the flat assignment vector into the 20 named variable buses.
// Latency: combinational. Backpressure: none (pure wiring).
// Ports: assign_vec in (TOTAL_W bits); var_0..var_19 out, widths from VAR_W.
module split_vec_unpack
   import split_pkg::*;
(
   input  logic [TOTAL_W-1:0]   assign_vec,
   output logic [VAR_W[0]-1:0]  var_0,
   output logic [VAR_W[1]-1:0]  var_1,
   output logic [VAR_W[2]-1:0]  var_2,
   output logic [VAR_W[3]-1:0]  var_3,
   output logic [VAR_W[4]-1:0]  var_4,
   output logic [VAR_W[5]-1:0]  var_5,
   output logic [VAR_W[6]-1:0]  var_6,
   output logic [VAR_W[7]-1:0]  var_7,
   output logic [VAR_W[8]-1:0]  var_8,
   output logic [VAR_W[9]-1:0]  var_9,
   output logic [VAR_W[10]-1:0] var_10,
   output logic [VAR_W[11]-1:0] var_11,
   output logic [VAR_W[12]-1:0] var_12,
   output logic [VAR_W[13]-1:0] var_13,
   output logic [VAR_W[14]-1:0] var_14,
   output logic [VAR_W[15]-1:0] var_15,
   output logic [VAR_W[16]-1:0] var_16,
   output logic [VAR_W[17]-1:0] var_17,
   output logic [VAR_W[18]-1:0] var_18,
   output logic [VAR_W[19]-1:0] var_19
);

   assign var_0  = assign_vec[VAR_OFF[0]  +: VAR_W[0]];
   assign var_1  = assign_vec[VAR_OFF[1]  +: VAR_W[1]];
   assign var_2  = assign_vec[VAR_OFF[2]  +: VAR_W[2]];
   assign var_3  = assign_vec[VAR_OFF[3]  +: VAR_W[3]];
   assign var_4  = assign_vec[VAR_OFF[4]  +: VAR_W[4]];
   assign var_5  = assign_vec[VAR_OFF[5]  +: VAR_W[5]];
   assign var_6  = assign_vec[VAR_OFF[6]  +: VAR_W[6]];
   assign var_7  = assign_vec[VAR_OFF[7]  +: VAR_W[7]];
   assign var_8  = assign_vec[VAR_OFF[8]  +: VAR_W[8]];
   assign var_9  = assign_vec[VAR_OFF[9]  +: VAR_W[9]];
   assign var_10 = assign_vec[VAR_OFF[10] +: VAR_W[10]];
   assign var_11 = assign_vec[VAR_OFF[11] +: VAR_W[11]];
   assign var_12 = assign_vec[VAR_OFF[12] +: VAR_W[12]];
   assign var_13 = assign_vec[VAR_OFF[13] +: VAR_W[13]];
   assign var_14 = assign_vec[VAR_OFF[14] +: VAR_W[14]];
   assign var_15 = assign_vec[VAR_OFF[15] +: VAR_W[15]];
   assign var_16 = assign_vec[VAR_OFF[16] +: VAR_W[16]];
   assign var_17 = assign_vec[VAR_OFF[17] +: VAR_W[17]];
   assign var_18 = assign_vec[VAR_OFF[18] +: VAR_W[18]];
   assign var_19 = assign_vec[VAR_OFF[19] +: VAR_W[19]];

endmodule

// File: rtl/split_assign_loader.sv
// Loads a 21-word assignment frame, holds it under check, returns pass/fail with framing-error detection.
// Latency: last-word handshake to res_valid is CHK_LAT+1 cycles (0 cycles of CHECK on framing errors).
// Backpressure: s_ready drops in CHECK/RESP; the result is held until res_valid & res_ready.
// Ports: clk/rst (async active-high); s_valid/s_ready/s_data/s_last word stream in;
//        assign_vec/assign_valid to the checker, chk_x back; res_valid/res_ready/res_pass/res_err
//        result out; frame_cnt/pass_cnt saturating counters.
module split_assign_loader
   import split_pkg::*;
#(
   parameter int CHK_LAT = 0,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WORD_W-1:0]  s_data,
   input  logic               s_last,
   output logic [TOTAL_W-1:0] assign_vec,
   output logic               assign_valid,
   input  logic               chk_x,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_pass,
   output logic               res_err,
   output logic [CNT_W-1:0]   frame_cnt,
   output logic [CNT_W-1:0]   pass_cnt
);

   localparam int LAT_W = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;
   localparam int IDX_W = $clog2(WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_d;
   logic [IDX_W-1:0] widx;
   logic [LAT_W-1:0] lat_cnt;
   logic             live;      // holds s_ready low for the first cycle out of reset
   logic             xfer;
   logic             last_idx;
   logic             lat_done;
   logic             res_hs;

   assign s_ready      = live & ((state == LOAD) | (state == DRAIN));
   assign assign_valid = (state == CHECK);
   assign res_valid    = (state == RESP);
   assign xfer         = s_valid & s_ready;
   assign last_idx     = (widx == IDX_W'(WORDS - 1));
   assign lat_done     = (lat_cnt == LAT_W'(CHK_LAT));
   assign res_hs       = res_valid & res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         LOAD: begin
            if (xfer) begin
               if (s_last)        state_d = last_idx ? CHECK : RESP;
               else if (last_idx) state_d = DRAIN;
            end
         end
         DRAIN: if (xfer && s_last) state_d = RESP;
         CHECK: if (lat_done)       state_d = RESP;
         RESP:  if (res_ready)      state_d = LOAD;
         default:                   state_d = LOAD;
      endcase
   end

   // Word packing and frame index. Only the low LAST_W bits of the final word land in the vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live       <= 1'b0;
         widx       <= '0;
         assign_vec <= '0;
      end else begin
         live <= 1'b1;
         if (state == LOAD && xfer) begin
            widx <= widx + 1'b1;
            for (int k = 0; k < WORDS - 1; k++) begin
               if (widx == IDX_W'(k)) assign_vec[k*WORD_W +: WORD_W] <= s_data;
            end
            if (last_idx) assign_vec[TOTAL_W-1 -: LAST_W] <= s_data[LAST_W-1:0];
         end
         if (res_hs) widx <= '0;
      end
   end

   // Check timing and result capture. Framing errors force res_pass low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt  <= '0;
         res_pass <= 1'b0;
         res_err  <= 1'b0;
      end else begin
         if (state == LOAD && xfer && s_last && !last_idx) begin
            res_err  <= 1'b1;
            res_pass <= 1'b0;
         end
         if (state == DRAIN && xfer && s_last) begin
            res_err  <= 1'b1;
            res_pass <= 1'b0;
         end
         if (state == CHECK) begin
            if (lat_done) begin
               lat_cnt  <= '0;
               res_pass <= chk_x;
               res_err  <= 1'b0;
            end else begin
               lat_cnt <= lat_cnt + 1'b1;
            end
         end
         if (res_hs) begin
            res_pass <= 1'b0;
            res_err  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         pass_cnt  <= '0;
      end else if (res_hs) begin
         if (frame_cnt != CNT_MAX)             frame_cnt <= frame_cnt + 1'b1;
         if (res_pass && pass_cnt != CNT_MAX)  pass_cnt  <= pass_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_split_assign_loader.sv
// Directed bench for split_assign_loader: one instance with CHK_LAT=0 (checker x=1),
// one with CHK_LAT=2 (checker x=0). Inputs driven and outputs sampled on the falling edge.
module tb_split_assign_loader;
   import split_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               s_valid   [2];
   logic               s_ready   [2];
   logic [WORD_W-1:0]  s_data    [2];
   logic               s_last    [2];
   logic [TOTAL_W-1:0] av        [2];
   logic               av_vld    [2];
   logic               chk_x     [2];
   logic               res_valid [2];
   logic               res_ready [2];
   logic               res_pass  [2];
   logic               res_err   [2];
   logic [15:0]        fcnt      [2];
   logic [15:0]        pcnt      [2];

   // Bench-side model state
   logic [TOTAL_W-1:0] mdl_vec [2];
   int                 mdl_idx [2];
   int                 exp_f   [2];
   int                 exp_p   [2];

   int n_checks = 0;
   int n_fail   = 0;

   split_assign_loader #(.CHK_LAT(0), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
      .assign_vec(av[0]), .assign_valid(av_vld[0]), .chk_x(chk_x[0]),
      .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_pass(res_pass[0]),
      .res_err(res_err[0]), .frame_cnt(fcnt[0]), .pass_cnt(pcnt[0])
   );

   split_assign_loader #(.CHK_LAT(2), .CNT_W(16)) u_dut2 (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
      .assign_vec(av[1]), .assign_valid(av_vld[1]), .chk_x(chk_x[1]),
      .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_pass(res_pass[1]),
      .res_err(res_err[1]), .frame_cnt(fcnt[1]), .pass_cnt(pcnt[1])
   );

   logic [VAR_W[0]-1:0]  uv0;   logic [VAR_W[1]-1:0]  uv1;   logic [VAR_W[2]-1:0]  uv2;
   logic [VAR_W[3]-1:0]  uv3;   logic [VAR_W[4]-1:0]  uv4;   logic [VAR_W[5]-1:0]  uv5;
   logic [VAR_W[6]-1:0]  uv6;   logic [VAR_W[7]-1:0]  uv7;   logic [VAR_W[8]-1:0]  uv8;
   logic [VAR_W[9]-1:0]  uv9;   logic [VAR_W[10]-1:0] uv10;  logic [VAR_W[11]-1:0] uv11;
   logic [VAR_W[12]-1:0] uv12;  logic [VAR_W[13]-1:0] uv13;  logic [VAR_W[14]-1:0] uv14;
   logic [VAR_W[15]-1:0] uv15;  logic [VAR_W[16]-1:0] uv16;  logic [VAR_W[17]-1:0] uv17;
   logic [VAR_W[18]-1:0] uv18;  logic [VAR_W[19]-1:0] uv19;

   split_vec_unpack u_unpack (
      .assign_vec(av[0]),
      .var_0(uv0),   .var_1(uv1),   .var_2(uv2),   .var_3(uv3),   .var_4(uv4),
      .var_5(uv5),   .var_6(uv6),   .var_7(uv7),   .var_8(uv8),   .var_9(uv9),
      .var_10(uv10), .var_11(uv11), .var_12(uv12), .var_13(uv13), .var_14(uv14),
      .var_15(uv15), .var_16(uv16), .var_17(uv17), .var_18(uv18), .var_19(uv19)
   );

   task automatic check_val(input string tag, input logic [TOTAL_W-1:0] got,
                            input logic [TOTAL_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the word transferred.
   task automatic send_word(input int d, input logic [WORD_W-1:0] w, input logic last);
      int guard = 0;
      s_valid[d] = 1'b1;
      s_data[d]  = w;
      s_last[d]  = last;
      while (!s_ready[d] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_val("s_ready_wait", {653'd0, s_ready[d]}, 654'd1);
      @(negedge clk);
      if (mdl_idx[d] < WORDS - 1)      mdl_vec[d][mdl_idx[d]*WORD_W +: WORD_W] = w;
      else if (mdl_idx[d] == WORDS - 1) mdl_vec[d][TOTAL_W-1 -: LAST_W] = w[LAST_W-1:0];
      mdl_idx[d]++;
      s_valid[d] = 1'b0;
      s_data[d]  = 32'hDEAD_BEEF;
      s_last[d]  = 1'b0;
   endtask

   task automatic send_frame(input int d, input int n, input int last_at,
                             input logic [WORD_W-1:0] base, input bit gaps);
      mdl_idx[d] = 0;
      for (int k = 0; k < n; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_word(d, base + WORD_W'(k), k == last_at);
      end
   endtask

   task automatic finish_frame(input int d, input int exp_lat, input int exp_avc,
                               input logic exp_pass, input logic exp_err, input int hold);
      int g   = 0;
      int avc = 0;
      while (!res_valid[d] && g < 40) begin
         if (av_vld[d]) avc++;
         @(negedge clk);
         g++;
      end
      check_val("res_valid", {653'd0, res_valid[d]}, 654'd1);
      check_val("latency", TOTAL_W'(g), TOTAL_W'(exp_lat));
      check_val("assign_valid_cycles", TOTAL_W'(avc), TOTAL_W'(exp_avc));
      check_val("res_pass", {653'd0, res_pass[d]}, {653'd0, exp_pass});
      check_val("res_err", {653'd0, res_err[d]}, {653'd0, exp_err});
      check_val("assign_vec", av[d], mdl_vec[d]);
      for (int i = 0; i < hold; i++) begin
         s_valid[d] = i[0];   // stray words must be refused while the result is pending
         @(negedge clk);
         check_val("hold", {650'd0, res_valid[d], res_pass[d], res_err[d], s_ready[d]},
                   {650'd0, 1'b1, exp_pass, exp_err, 1'b0});
      end
      s_valid[d]   = 1'b0;
      res_ready[d] = 1'b1;
      @(negedge clk);
      res_ready[d] = 1'b0;
      exp_f[d]++;
      if (exp_pass) exp_p[d]++;
      check_val("res_valid_after", {653'd0, res_valid[d]}, 654'd0);
      check_val("s_ready_after", {653'd0, s_ready[d]}, 654'd1);
      check_val("frame_cnt", {638'd0, fcnt[d]}, TOTAL_W'(exp_f[d]));
      check_val("pass_cnt", {638'd0, pcnt[d]}, TOTAL_W'(exp_p[d]));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         s_valid[d] = 1'b0; s_data[d] = '0; s_last[d] = 1'b0; res_ready[d] = 1'b0;
         mdl_vec[d] = '0; mdl_idx[d] = 0; exp_f[d] = 0; exp_p[d] = 0;
      end
      chk_x[0] = 1'b1;
      chk_x[1] = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_s_ready", {653'd0, s_ready[0]}, 654'd0);
      check_val("rst_outs", {651'd0, av_vld[0], res_valid[0], res_pass[0], res_err[0]}, 654'd0);
      check_val("rst_cnts", {622'd0, fcnt[0], pcnt[0]}, 654'd0);
      check_val("rst_vec", av[0], '0);
      rst = 1'b0;
      @(negedge clk);
      check_val("s_ready_post_rst", {653'd0, s_ready[0]}, 654'd1);

      // Good frame, CHK_LAT=0, x=1
      send_frame(0, 21, 20, 32'hA5A5_0000, 1'b0);
      finish_frame(0, 1, 1, 1'b1, 1'b0, 0);
      check_val("vec_w0", {622'd0, av[0][31:0]}, {622'd0, 32'hA5A5_0000});
      check_val("var_0", {627'd0, uv0}, {627'd0, 27'h5A5_0000});
      check_val("var_19", {634'd0, uv19}, {634'd0, 20'h00529});

      // Same frame, CHK_LAT=2, x=0
      send_frame(1, 21, 20, 32'hA5A5_0000, 1'b0);
      finish_frame(1, 3, 3, 1'b0, 1'b0, 0);

      // Short frame: s_last on word 5
      send_frame(0, 6, 5, 32'h0BAD_0000, 1'b0);
      finish_frame(0, 0, 0, 1'b0, 1'b1, 0);

      // Long frame: 25 words, s_last on word 24
      send_frame(0, 25, 24, 32'h1234_0000, 1'b0);
      finish_frame(0, 0, 0, 1'b0, 1'b1, 0);

      // Good frame with input gaps and 10 cycles of result backpressure
      send_frame(0, 21, 20, 32'h5A5A_0100, 1'b1);
      finish_frame(0, 1, 1, 1'b1, 1'b0, 10);

      // Async reset in the middle of a frame
      send_frame(0, 10, 99, 32'h7777_0000, 1'b0);
      s_valid[0] = 1'b1;
      s_data[0]  = 32'h7777_000A;
      #2 rst = 1'b1;
      #1;
      check_val("mid_rst_s_ready", {653'd0, s_ready[0]}, 654'd0);
      check_val("mid_rst_outs", {651'd0, av_vld[0], res_valid[0], res_pass[0], res_err[0]}, 654'd0);
      check_val("mid_rst_cnts", {622'd0, fcnt[0], pcnt[0]}, 654'd0);
      check_val("mid_rst_vec", av[0], '0);
      for (int d = 0; d < 2; d++) begin
         mdl_vec[d] = '0; exp_f[d] = 0; exp_p[d] = 0;
      end
      s_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_frame(0, 21, 20, 32'hC0DE_0000, 1'b0);
      finish_frame(0, 1, 1, 1'b1, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
